// File: rtl/hilo_mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: request opcodes and FSM states.
package hilo_mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Magnitude restoring radix-2 divider: one quotient bit per cycle for WIDTH cycles.
// quotient/remainder show the values after the current iteration, so the caller can capture them on 'last'.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    fits      = ~trial[WIDTH];
    remainder = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
  end

  assign busy = busy_q;
  assign last = busy_q & (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= remainder;
      quo_q  <= quotient;
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= ~flush & (cnt_q != CW'(1));
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative mult/multu/div/divu unit for the EX stage with valid/ready intake,
// stall request, annul-on-flush and registered {hi, lo} result strobe.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             annul,
  output logic             stall_req,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int MCW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam int MUL_LOAD = (MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0;

  mdu_state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             q_neg_q, r_neg_q;
  logic [MCW-1:0]   mul_cnt;

  logic             accept, op_is_div, op_signed, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_sgn;
  logic [2*WIDTH-1:0] product;
  logic             div_start, div_flush, div_busy, div_last;
  logic [WIDTH-1:0] div_q, div_r, q_fix, r_fix;

  function automatic logic [2*WIDTH-1:0] full_product(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  assign op_is_div = req_op[1];
  assign op_signed = ~req_op[0];
  assign div_zero  = (src_b == '0);
  assign accept    = (state == ST_IDLE) & req_valid & ~annul;

  assign req_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign stall_req = (state == ST_MUL) | (state == ST_DIV) |
                     ((state == ST_IDLE) & req_valid & ~annul);

  // One multiplier: fed straight from the request when the latency is a single cycle,
  // otherwise from the latched operands while the count drains.
  assign mul_a   = (state == ST_IDLE) ? src_a : a_q;
  assign mul_b   = (state == ST_IDLE) ? src_b : b_q;
  assign mul_sgn = (state == ST_IDLE) ? op_signed : signed_q;
  assign product = full_product(mul_a, mul_b, mul_sgn);

  assign abs_a = (op_signed & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (op_signed & src_b[WIDTH-1]) ? -src_b : src_b;

  assign div_start = accept & op_is_div & ~div_zero;
  assign div_flush = (state == ST_DIV) & annul;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .flush     (div_flush),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .busy      (div_busy),
    .last      (div_last),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // MIN / -1 needs no special path: |MIN| / 1 negated wraps back to MIN with remainder 0.
  assign q_fix = q_neg_q ? -div_q : div_q;
  assign r_fix = r_neg_q ? -div_r : div_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_div)             next_state = div_zero ? ST_DONE : ST_DIV;
          else if (MUL_LATENCY == 1) next_state = ST_DONE;
          else                       next_state = ST_MUL;
        end
      end
      ST_MUL:  if (annul) next_state = ST_IDLE;
               else if (mul_cnt == '0) next_state = ST_DONE;
      ST_DIV:  if (annul) next_state = ST_IDLE;
               else if (div_last) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      mul_cnt  <= '0;
    end else if (accept) begin
      a_q      <= src_a;
      b_q      <= src_b;
      signed_q <= op_signed;
      q_neg_q  <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      r_neg_q  <= op_signed & src_a[WIDTH-1];
      mul_cnt  <= MCW'(MUL_LOAD);
    end else if ((state == ST_MUL) && (mul_cnt != '0)) begin
      mul_cnt  <= mul_cnt - MCW'(1);
    end
  end

  // Result registers change only on the edge that enters DONE and hold afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_hi <= '0;
      res_lo <= '0;
    end else if (accept && op_is_div && div_zero) begin
      res_hi <= src_a;
      res_lo <= '1;
    end else if (accept && !op_is_div && (MUL_LATENCY == 1)) begin
      {res_hi, res_lo} <= product;
    end else if ((state == ST_MUL) && !annul && (mul_cnt == '0)) begin
      {res_hi, res_lo} <= product;
    end else if ((state == ST_DIV) && !annul && div_last) begin
      res_hi <= r_fix;
      res_lo <= q_fix;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: a 32-bit instance (MUL_LATENCY=2) and a 16-bit instance (MUL_LATENCY=3).
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        annul;

  logic        v32, rdy32, stall32, rv32;
  logic [31:0] hi32, lo32;
  logic        v16, rdy16, stall16, rv16;
  logic [15:0] hi16, lo16;

  int nPassed = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(32), .MUL_LATENCY(2)) dut32 (
    .clk(clk), .resetn(resetn), .req_valid(v32), .req_ready(rdy32), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .annul(annul), .stall_req(stall32),
    .res_valid(rv32), .res_hi(hi32), .res_lo(lo32));

  hilo_mdu #(.WIDTH(16), .MUL_LATENCY(3)) dut16 (
    .clk(clk), .resetn(resetn), .req_valid(v16), .req_ready(rdy16), .req_op(req_op),
    .src_a(src_a[15:0]), .src_b(src_b[15:0]), .annul(annul), .stall_req(stall16),
    .res_valid(rv16), .res_hi(hi16), .res_lo(lo16));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPassed++;
    else $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // One request on the chosen instance, checking stall/valid every cycle up to the result cycle.
  task automatic applyStimulus(input bit w16, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input int lat, input string tag);
    @(negedge clk);
    req_op = op; src_a = a; src_b = b;
    if (w16) v16 = 1'b1; else v32 = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, 32'(w16 ? rdy16 : rdy32), 32'd1);
    checkOutput({tag, "_stall_t"}, 32'(w16 ? stall16 : stall32), 32'd1);
    @(posedge clk);
    #1 v16 = 1'b0; v32 = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        checkOutput({tag, "_valid_early"}, 32'(w16 ? rv16 : rv32), 32'd0);
        checkOutput({tag, "_stall_busy"}, 32'(w16 ? stall16 : stall32), 32'd1);
      end else begin
        checkOutput({tag, "_valid"}, 32'(w16 ? rv16 : rv32), 32'd1);
        checkOutput({tag, "_stall_done"}, 32'(w16 ? stall16 : stall32), 32'd0);
        checkOutput({tag, "_hi"}, w16 ? {16'd0, hi16} : hi32, exp_hi);
        checkOutput({tag, "_lo"}, w16 ? {16'd0, lo16} : lo32, exp_lo);
      end
    end
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; v32 = 1'b0; v16 = 1'b0; annul = 1'b0;
    req_op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(rdy32), 32'd1);
    checkOutput("rst_valid", 32'(rv32), 32'd0);
    checkOutput("rst_stall", 32'(stall32), 32'd0);
    checkOutput("rst_hi", hi32, 32'd0);
    checkOutput("rst_lo", lo32, 32'd0);
    resetn = 1'b1;

    applyStimulus(0, 2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mult");
    applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 2, "multu");
    applyStimulus(0, 2'b00, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 2, "mult_pos");
    applyStimulus(0, 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg");
    applyStimulus(0, 2'b10, 32'h7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div_negb");

    // Annul a divide at t+10: unit is idle at t+11 and the old result is kept.
    @(negedge clk);
    req_op = 2'b10; src_a = 32'd1000; src_b = 32'd3; v32 = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    checkOutput("annul_ready", 32'(rdy32), 32'd1);
    checkOutput("annul_stall", 32'(stall32), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rv32) seen = 1'b1;
    end
    checkOutput("annul_no_valid", 32'(seen), 32'd0);
    checkOutput("annul_lo_held", lo32, 32'hFFFF_FFFD);

    applyStimulus(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu");
    applyStimulus(0, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, "divu_zero");
    applyStimulus(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, "div_ovf");

    applyStimulus(1, 2'b00, 32'hFFFF, 32'h2, 32'hFFFF, 32'hFFFE, 3, "w16_mult");

    // Reset in the middle of a 16-bit multiply clears everything at once.
    @(negedge clk);
    req_op = 2'b00; src_a = 32'd3; src_b = 32'd5; v16 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rstmid_hi", {16'd0, hi16}, 32'd0);
    checkOutput("rstmid_lo", {16'd0, lo16}, 32'd0);
    checkOutput("rstmid_valid", 32'(rv16), 32'd0);
    checkOutput("rstmid_stall", 32'(stall16), 32'd0);
    checkOutput("rstmid_ready", 32'(rdy16), 32'd1);
    checkOutput("rstmid_lo32", lo32, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1, 2'b00, 32'h3, 32'hFFFB, 32'hFFFF, 32'hFFF1, 3, "w16_mult_after");
    applyStimulus(1, 2'b10, 32'hFFF9, 32'h2, 32'hFFFF, 32'hFFFD, 17, "w16_div_neg");
    applyStimulus(1, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 17, "w16_divu");
    applyStimulus(1, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF, 1, "w16_divu_zero");
    applyStimulus(1, 2'b10, 32'h8000, 32'hFFFF, 32'd0, 32'h8000, 17, "w16_div_ovf");

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
